// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue sequencer: op codes, FSM state encoding
// and latency classes.
package fpu_pkg;

  localparam logic [4:0] FADD_D         = 5'b00000;
  localparam logic [4:0] FSUB_D         = 5'b00001;
  localparam logic [4:0] FMUL_D         = 5'b00010;
  localparam logic [4:0] FDIV_D         = 5'b00011;
  localparam logic [4:0] FSQRT_D        = 5'b00100;
  localparam logic [4:0] FSGNJ_D        = 5'b00101;
  localparam logic [4:0] FCVT_D_S       = 5'b00110;
  localparam logic [4:0] FMV_X_D        = 5'b00111;
  localparam logic [4:0] FMV_D_X        = 5'b01000;
  localparam logic [4:0] FADD_S         = 5'b01001;
  localparam logic [4:0] FSUB_S         = 5'b01010;
  localparam logic [4:0] FMUL_S         = 5'b01011;
  localparam logic [4:0] FDIV_S         = 5'b01100;
  localparam logic [4:0] FSQRT_S        = 5'b01101;
  localparam logic [4:0] FPU_OP_ILLEGAL = 5'b11111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef enum logic [2:0] {LC_ADD, LC_MUL, LC_DIV, LC_SQRT, LC_ONE, LC_ILL} lat_class_t;

  function automatic lat_class_t op_class(input logic [4:0] op);
    lat_class_t c;
    case (op)
      FADD_D, FSUB_D, FADD_S, FSUB_S:       c = LC_ADD;
      FMUL_D, FMUL_S:                       c = LC_MUL;
      FDIV_D, FDIV_S:                       c = LC_DIV;
      FSQRT_D, FSQRT_S:                     c = LC_SQRT;
      FSGNJ_D, FCVT_D_S, FMV_X_D, FMV_D_X:  c = LC_ONE;
      default:                              c = LC_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Combinational op-code to latency lookup; flags op codes outside the legal set.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic [4:0]       op,
  output logic [CNT_W-1:0] lat,
  output logic             illegal
);

  always_comb begin
    lat     = CNT_W'(1);
    illegal = 1'b0;
    case (op_class(op))
      LC_ADD:  lat = CNT_W'(ADD_LAT);
      LC_MUL:  lat = CNT_W'(MUL_LAT);
      LC_DIV:  lat = CNT_W'(DIV_LAT);
      LC_SQRT: lat = CNT_W'(SQRT_LAT);
      LC_ONE:  lat = CNT_W'(1);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Single-issue FPU sequencer: latches one decoded op, times its fixed latency and
// holds the result on a backpressured writeback port. Optional flush: FPU_FLUSH_EN.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FPU_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      fpu_op,
  input  logic            fpu_rd,
  input  logic            fpu_rs1,
  input  logic [4:0]      rd_idx,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            dp_start,
  output logic [4:0]      dp_op,
  output logic [XLEN-1:0] dp_a,
  output logic [XLEN-1:0] dp_b,
  output logic            dp_rs1_fp,
  input  logic [XLEN-1:0] dp_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_idx,
  output logic            wb_to_fp,
  output logic            busy,
  output logic            illegal
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lut_lat;
  logic             lut_illegal;
  logic [4:0]       rd_idx_q;
  logic             rd_fp_q;
  logic             flush_i;
  logic             accept;

`ifdef FPU_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  fpu_lat_lut #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .SQRT_LAT(SQRT_LAT),
    .CNT_W   (CNT_W)
  ) u_lat_lut (
    .op     (fpu_op),
    .lat    (lut_lat),
    .illegal(lut_illegal)
  );

  // Gated by rst_n so the port reads 0 while reset is asserted.
  assign in_ready = rst_n & ~flush_i & ((state == IDLE) | ((state == WB) & wb_ready));
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dp_start  <= 1'b0;
      dp_op     <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_rs1_fp <= 1'b0;
      rd_idx_q  <= '0;
      rd_fp_q   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd_idx <= '0;
      wb_to_fp  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      illegal  <= 1'b0;
      if (flush_i) begin
        state    <= IDLE;
        wb_valid <= 1'b0;
      end else begin
        case (state)
          EXEC: begin
            if (cnt == CNT_W'(1)) begin
              wb_data   <= dp_result;
              wb_rd_idx <= rd_idx_q;
              wb_to_fp  <= rd_fp_q;
              wb_valid  <= 1'b1;
              state     <= WB;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          WB: begin
            if (wb_ready) begin
              wb_valid <= 1'b0;
              state    <= IDLE;
            end
          end
          default: ;
        endcase
        // Accepts only happen in IDLE or on the WB drain edge, so these win over the above.
        if (accept) begin
          if (lut_illegal) begin
            illegal <= 1'b1;
          end else begin
            dp_op     <= fpu_op;
            dp_a      <= op_a;
            dp_b      <= op_b;
            dp_rs1_fp <= fpu_rs1;
            rd_idx_q  <= rd_idx;
            rd_fp_q   <= fpu_rd;
            cnt       <= lut_lat;
            dp_start  <= 1'b1;
            state     <= EXEC;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq; flush scenario is built when FPU_FLUSH_EN is defined.
module tb_fpu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [4:0]  fpu_op;
  logic        fpu_rd, fpu_rs1;
  logic [4:0]  rd_idx;
  logic [63:0] op_a, op_b;
  logic        dp_start;
  logic [4:0]  dp_op;
  logic [63:0] dp_a, dp_b;
  logic        dp_rs1_fp;
  logic [63:0] dp_result;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd_idx;
  logic        wb_to_fp, busy, illegal;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  fpu_issue_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FPU_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fpu_op   (fpu_op),
    .fpu_rd   (fpu_rd),
    .fpu_rs1  (fpu_rs1),
    .rd_idx   (rd_idx),
    .op_a     (op_a),
    .op_b     (op_b),
    .dp_start (dp_start),
    .dp_op    (dp_op),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_rs1_fp(dp_rs1_fp),
    .dp_result(dp_result),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_data  (wb_data),
    .wb_rd_idx(wb_rd_idx),
    .wb_to_fp (wb_to_fp),
    .busy     (busy),
    .illegal  (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic rd, input logic rs1,
                       input logic [4:0] idx, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    fpu_op   = op;
    fpu_rd   = rd;
    fpu_rs1  = rs1;
    rd_idx   = idx;
    op_a     = a;
    op_b     = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; fpu_op = '0; fpu_rd = 1'b0;
    fpu_rs1 = 1'b0; rd_idx = '0; op_a = '0; op_b = '0; dp_result = '0; wb_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_dp_a", dp_a, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step();

    // fadd.d, latency 2
    issue(5'b00000, 1'b1, 1'b1, 5'd3, 64'h3FF0000000000000, 64'h3FF0000000000000);
    dp_result = 64'h4000000000000000;
    step();
    in_valid = 1'b0;
    chk("add_dp_start", dp_start, 1);
    chk("add_dp_op", dp_op, 5'b00000);
    chk("add_dp_a", dp_a, 64'h3FF0000000000000);
    chk("add_dp_rs1_fp", dp_rs1_fp, 1);
    chk("add_busy", busy, 1);
    step();
    chk("add_dp_start_drop", dp_start, 0);
    chk("add_wb_early", wb_valid, 0);
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_data, 64'h4000000000000000);
    chk("add_wb_to_fp", wb_to_fp, 1);
    chk("add_wb_rd_idx", wb_rd_idx, 5'd3);
    step();
    chk("add_wb_drained", wb_valid, 0);
    chk("add_idle", busy, 0);

    // fdiv.s followed back-to-back by fmv.x.d
    issue(5'b01100, 1'b1, 1'b1, 5'd4, 64'h11, 64'h22);
    dp_result = 64'h000000000000AAAA;
    step();
    issue(5'b00111, 1'b0, 1'b1, 5'd7, 64'h1234, 64'h0);
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      step();
    end
    chk("div_stall_cycles", n, 12);
    chk("div_wb_valid", wb_valid, 1);
    chk("div_wb_data", wb_data, 64'hAAAA);
    chk("div_wb_rd_idx", wb_rd_idx, 5'd4);
    dp_result = 64'h0000000000005555;
    step();
    in_valid = 1'b0;
    chk("fmv_zero_bubble_start", dp_start, 1);
    chk("fmv_dp_op", dp_op, 5'b00111);
    chk("fmv_wb_gap", wb_valid, 0);
    step();
    chk("fmv_wb_valid", wb_valid, 1);
    chk("fmv_wb_data", wb_data, 64'h5555);
    chk("fmv_wb_to_fp", wb_to_fp, 0);
    chk("fmv_wb_rd_idx", wb_rd_idx, 5'd7);
    step();

    // fsqrt.d with writeback backpressure, then same-edge fmul.s issue
    wb_ready = 1'b0;
    issue(5'b00100, 1'b1, 1'b1, 5'd9, 64'h5, 64'h0);
    dp_result = 64'h1111;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("sqrt_wb_early", wb_valid, 0);
    step();
    chk("sqrt_wb_valid", wb_valid, 1);
    chk("sqrt_wb_data", wb_data, 64'h1111);
    dp_result = 64'h2222;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_valid === 1'b1 && wb_data === 64'h1111 && in_ready === 1'b0) n++;
    end
    chk("sqrt_wb_held", n, 4);
    wb_ready = 1'b1;
    issue(5'b01011, 1'b1, 1'b0, 5'd10, 64'h6, 64'h7);
    chk("sqrt_drain_in_ready", in_ready, 1);
    dp_result = 64'h3333;
    step();
    in_valid = 1'b0;
    chk("mul_start", dp_start, 1);
    chk("mul_wb_gap", wb_valid, 0);
    step();
    step();
    chk("mul_wb_early", wb_valid, 0);
    step();
    chk("mul_wb_valid", wb_valid, 1);
    chk("mul_wb_data", wb_data, 64'h3333);
    chk("mul_wb_rd_idx", wb_rd_idx, 5'd10);
    step();

    // Illegal op codes 11111 and 01110
    issue(5'b11111, 1'b1, 1'b1, 5'd1, 64'h0, 64'h0);
    chk("ill_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_no_start", dp_start, 0);
    chk("ill_not_busy", busy, 0);
    chk("ill_in_ready_after", in_ready, 1);
    step();
    chk("ill_pulse_end", illegal, 0);
    chk("ill_no_wb", wb_valid, 0);
    issue(5'b01110, 1'b1, 1'b1, 5'd1, 64'h0, 64'h0);
    step();
    in_valid = 1'b0;
    chk("ill_01110_pulse", illegal, 1);
    chk("ill_01110_no_start", dp_start, 0);
    step();

    // Reset in the middle of fdiv.d
    issue(5'b00011, 1'b1, 1'b1, 5'd12, 64'h99, 64'h98);
    dp_result = 64'h7777;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_dp_a", dp_a, 0);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (wb_valid !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("mid_rst_no_stale_wb", n, 0);

`ifdef FPU_FLUSH_EN
    // Flush during fdiv.d with a concurrent request
    issue(5'b00011, 1'b1, 1'b1, 5'd13, 64'h1, 64'h2);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    flush = 1'b1;
    issue(5'b00000, 1'b1, 1'b1, 5'd14, 64'h3, 64'h4);
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_no_start", dp_start, 0);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (wb_valid !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("flush_no_wb", n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
